// File: rtl/result_scanner_pkg.sv
// Shared constants, status layout and FSM state encoding for the bcrypt result scanner.
package result_scanner_pkg;

  localparam int unsigned NUM_OF_CORES_DEF = 14;
  localparam int unsigned RESULT_BASE_DEF  = 32'd4260;
  localparam int unsigned RECORD_BYTES_DEF = 32'd8;
  localparam int unsigned WORD_BYTES       = 4;

  localparam logic [31:0] ALL_DONE_VAL = 32'hFF;

  localparam int unsigned ST_BUSY_BIT = 0;
  localparam int unsigned ST_DONE_BIT = 1;
  localparam int unsigned ST_ANY_BIT  = 2;
  localparam int unsigned ST_CNT_LSB  = 8;

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_REQ1,
    S_CAP0,
    S_CAP1,
    S_FIN
  } state_e;

endpackage

// File: rtl/result_scanner.sv
// Scans every core's 64-bit result in shared BRAM (port B) against a latched target
// once the arbiter reports all cores stored; exposes a match mask and scan status.
module result_scanner
  import result_scanner_pkg::*;
#(
  parameter int unsigned NUM_OF_CORES = NUM_OF_CORES_DEF,
  parameter int unsigned RESULT_BASE  = RESULT_BASE_DEF,
  parameter int unsigned RECORD_BYTES = RECORD_BYTES_DEF,
  parameter int unsigned C_SLV_DWIDTH = 32,
  parameter int unsigned C_MST_AWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_SLV_DWIDTH-1:0]   all_done,
  input  logic [C_SLV_DWIDTH-1:0]   target_lo,
  input  logic [C_SLV_DWIDTH-1:0]   target_hi,
  output logic                      BRAM_Rst_B,
  output logic                      BRAM_Clk_B,
  output logic                      BRAM_En_B,
  output logic [3:0]                BRAM_WE_B,
  output logic [C_MST_AWIDTH-1:0]   BRAM_Addr_B,
  output logic [C_SLV_DWIDTH-1:0]   BRAM_WrData_B,
  input  logic [C_SLV_DWIDTH-1:0]   BRAM_RdData_B,
  output logic [C_SLV_DWIDTH-1:0]   match_mask,
  output logic [C_SLV_DWIDTH-1:0]   scan_status
);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [C_MST_AWIDTH-1:0]   addr_q, addr_d;
  logic [C_SLV_DWIDTH-1:0]   tlo_q, tlo_d;
  logic [C_SLV_DWIDTH-1:0]   thi_q, thi_d;
  logic [C_SLV_DWIDTH-1:0]   w0_q, w0_d;
  logic [C_SLV_DWIDTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      prev_q;
  logic                      trig_q;

  logic                      all_done_c;
  logic [C_MST_AWIDTH-1:0]   rec_addr_c;
  logic                      hit_c;
  logic [C_SLV_DWIDTH-1:0]   status_c;

  assign all_done_c = (all_done == C_SLV_DWIDTH'(ALL_DONE_VAL));
  assign rec_addr_c = C_MST_AWIDTH'(RESULT_BASE + RECORD_BYTES * 32'(idx_q));
  assign hit_c      = ({BRAM_RdData_B, w0_q} == {thi_q, tlo_q});

  // Rising-edge detect of the completion condition; trig_q starts the scan one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      prev_q <= all_done_c;
      trig_q <= all_done_c & ~prev_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      tlo_q   <= '0;
      thi_q   <= '0;
      w0_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      tlo_q   <= tlo_d;
      thi_q   <= thi_d;
      w0_q    <= w0_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    tlo_d   = tlo_q;
    thi_d   = thi_q;
    w0_d    = w0_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;

    // Host withdrawing all_done mid-scan wins over any in-flight step, including the last compare.
    if (busy_q && !all_done_c) begin
      state_d = S_IDLE;
      idx_d   = '0;
      mask_d  = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (trig_q && all_done_c) begin
            state_d = S_REQ0;
            idx_d   = '0;
            tlo_d   = target_lo;
            thi_d   = target_hi;
            mask_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        S_REQ0: begin
          addr_d  = rec_addr_c;
          state_d = S_REQ1;
        end
        S_REQ1: begin
          addr_d  = rec_addr_c + C_MST_AWIDTH'(WORD_BYTES);
          state_d = S_CAP0;
        end
        S_CAP0: begin
          w0_d    = BRAM_RdData_B;
          state_d = S_CAP1;
        end
        S_CAP1: begin
          if (hit_c) begin
            mask_d[idx_q] = 1'b1;
            cnt_d         = cnt_q + CNT_W'(1);
          end
          if (32'(idx_q) < NUM_OF_CORES - 1) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_REQ0;
          end else begin
            state_d = S_FIN;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    status_c                          = '0;
    status_c[ST_BUSY_BIT]             = busy_q;
    status_c[ST_DONE_BIT]             = done_q;
    status_c[ST_ANY_BIT]              = |mask_q;
    status_c[ST_CNT_LSB +: CNT_W]     = cnt_q;
  end

  assign BRAM_Rst_B    = 1'b0;
  assign BRAM_Clk_B    = clk;
  assign BRAM_En_B     = 1'b1;
  assign BRAM_WE_B     = 4'b0000;
  assign BRAM_WrData_B = '0;
  assign BRAM_Addr_B   = addr_q;
  assign match_mask    = mask_q;
  assign scan_status   = status_c;

endmodule

// File: tb/tb_result_scanner.sv
// Directed bench for result_scanner: a BRAM model feeds records, a scoreboard checks each completed scan.
module tb_result_scanner;

  localparam int unsigned NCORES = 14;
  localparam int unsigned BASE   = 4260;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] all_done, target_lo, target_hi;
  logic        bram_rst, bram_clk, bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_wdata, bram_rdata;
  logic [31:0] match_mask, scan_status;

  result_scanner dut (
    .clk(clk), .rst(rst), .all_done(all_done),
    .target_lo(target_lo), .target_hi(target_hi),
    .BRAM_Rst_B(bram_rst), .BRAM_Clk_B(bram_clk), .BRAM_En_B(bram_en),
    .BRAM_WE_B(bram_we), .BRAM_Addr_B(bram_addr), .BRAM_WrData_B(bram_wdata),
    .BRAM_RdData_B(bram_rdata), .match_mask(match_mask), .scan_status(scan_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] status;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] mem [0:2047];
  logic [31:0] rdata_q = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          cap_en = 1'b0;
  bit          prev_done = 1'b0;
  logic [31:0] last_addr = '0;

  assign bram_rdata = rdata_q;

  // One-cycle synchronous read model
  always @(posedge clk) begin
    cyc++;
    rdata_q <= mem[bram_addr[12:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: each rising done pops one expected scan result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && scan_status[1] && !prev_done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("scan_mask", match_mask, e.mask);
        check("scan_status", scan_status, e.status);
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
    prev_done = scan_status[1];
    if (cap_en && bram_addr != last_addr) obs_addr.push_back(bram_addr);
    last_addr = bram_addr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = '0;
  endtask

  task automatic set_rec(input int k, input logic [31:0] w0, input logic [31:0] w1);
    mem[(BASE + 8 * k) / 4]     = w0;
    mem[(BASE + 8 * k) / 4 + 1] = w1;
  endtask

  // Raises all_done; leaves time one cycle after busy should have risen
  task automatic start_scan(input bit expect_done, input logic [31:0] m, input logic [31:0] st);
    exp_t e;
    all_done = 32'hFF;
    if (expect_done) begin
      e.mask     = m;
      e.status   = st;
      e.done_cyc = cyc + 1 + 4 * NCORES + 2;
      sb_q.push_back(e);
    end
    tick(1);
    check("busy_at_trigger", 32'(scan_status[0]), 32'd0);
    tick(1);
    check("busy_after_trigger", scan_status & 32'h3, 32'h1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!scan_status[1] && n < 100) begin
      tick(1);
      n++;
    end
    check({name, "_done_seen"}, 32'(scan_status[1]), 32'd1);
    tick(1);
  endtask

  task automatic end_scan();
    all_done = 32'h0;
    tick(2);
  endtask

  localparam logic [31:0] A_LO = 32'hCAFEF00D, A_HI = 32'h0BADBEEF;
  localparam logic [31:0] B_LO = 32'h12345678, B_HI = 32'h9ABCDEF0;

  initial begin
    rst = 1'b1;
    all_done = '0;
    target_lo = '0;
    target_hi = '0;
    clear_mem();
    tick(3);
    check("reset_mask", match_mask, 32'h0);
    check("reset_status", scan_status, 32'h0);
    check("reset_addr", bram_addr, 32'h0);
    check("tied_ctrl", {27'd0, bram_rst, bram_en, bram_we}, {27'd0, 1'b0, 1'b1, 4'h0});
    check("tied_wdata", bram_wdata, 32'h0);
    rst = 1'b0;
    tick(2);

    // Single match at core 3; held level must not retrigger
    set_rec(3, 32'h11223344, 32'hAABBCCDD);
    target_lo = 32'h11223344;
    target_hi = 32'hAABBCCDD;
    start_scan(1'b1, 32'h0000_0008, 32'h0000_0106);
    wait_done("single");
    tick(6);
    check("no_retrigger", scan_status, 32'h0000_0106);
    end_scan();

    // Half-matches at the first and last core
    clear_mem();
    set_rec(0, 32'h11223344, 32'h0);
    set_rec(NCORES - 1, 32'h0, 32'hAABBCCDD);
    start_scan(1'b1, 32'h0, 32'h0000_0002);
    wait_done("nomatch");
    end_scan();

    // All match, with address trace
    for (int k = 0; k < NCORES; k++) set_rec(k, 32'h11223344, 32'hAABBCCDD);
    obs_addr.delete();
    cap_en = 1'b1;
    start_scan(1'b1, 32'h0000_3FFF, 32'h0000_0E06);
    wait_done("allmatch");
    cap_en = 1'b0;
    check("addr_count", 32'(obs_addr.size()), 32'(2 * NCORES));
    for (int k = 0; k < 2 * NCORES && k < obs_addr.size(); k++)
      check($sformatf("addr_%0d", k), obs_addr[k], 32'(BASE + 4 * k));
    end_scan();

    // Reset during CAP0 of core 5
    start_scan(1'b0, 32'h0, 32'h0);
    tick(22);
    check("mask_before_reset", match_mask, 32'h0000_001F);
    rst = 1'b1;
    #1;
    check("midreset_mask", match_mask, 32'h0);
    check("midreset_status", scan_status, 32'h0);
    check("midreset_addr", bram_addr, 32'h0);
    all_done = 32'h0;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("idle_after_reset", scan_status, 32'h0);
    start_scan(1'b1, 32'h0000_3FFF, 32'h0000_0E06);
    wait_done("post_reset");
    end_scan();

    // Target changed mid-scan must not affect the latched compare
    clear_mem();
    set_rec(2, A_LO, A_HI);
    set_rec(4, B_LO, B_HI);
    set_rec(9, B_LO, B_HI);
    target_lo = A_LO;
    target_hi = A_HI;
    start_scan(1'b1, 32'h0000_0004, 32'h0000_0106);
    tick(8);
    target_lo = B_LO;
    target_hi = B_HI;
    wait_done("latched_target");
    end_scan();

    // Abort at core 7, then fresh scan
    start_scan(1'b0, 32'h0, 32'h0);
    tick(28);
    check("mask_before_abort", match_mask, 32'h0000_0010);
    all_done = 32'h0;
    tick(1);
    check("abort_status", scan_status, 32'h0);
    check("abort_mask", match_mask, 32'h0);
    tick(2);
    start_scan(1'b1, 32'h0000_0210, 32'h0000_0206);
    wait_done("after_abort");
    end_scan();

    tick(3);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
